uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo_if.sv | 12 +
 rtl/uart_tx_fifo_sync_fifo.sv | 53 +++++
 rtl/uart_tx_fifo.sv | 119 +++++++++++
 tb/tb_uart_tx_fifo.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: default bit timing, transmit FSM encoding and 8N1 frame fields.
// The receive stage imports the same package so one DELAY_FRAMES value sets both baud rates.
package uart_pkg;

  localparam int DELAY_FRAMES = 234;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake from a producer into the UART transmit FIFO.
// A byte transfers on a rising clock edge where tx_valid && tx_ready; tx_data is ignored otherwise.
interface uart_tx_fifo_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count; full and empty are derived from the count
// so the pointers can wrap naturally over their full range.
module sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: buffers bytes in a FIFO and sends them as 8N1 frames, LSB first,
// DELAY_FRAMES clocks per bit; a queued byte follows the stop bit with no idle gap.
module uart_tx_fifo #(
  parameter int DELAY_FRAMES = uart_pkg::DELAY_FRAMES,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = $clog2(FIFO_DEPTH)
) (
  input  logic              sys_clk,
  input  logic              rst,
  uart_tx_fifo_if.slave     tx_if,
  output logic              uart_tx,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic [1:0]        state
);

  import uart_pkg::*;

  localparam int CNT_W = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift, shift_n;
  logic [1:0]       state_n;
  logic             line_n;
  logic             bit_done;
  logic             pop;
  logic [7:0]       fifo_rd_data;
  logic             fifo_full;
  logic             fifo_empty;

  sync_fifo #(
    .WIDTH  (8),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (sys_clk),
    .rst     (rst),
    .wr_en   (tx_if.tx_valid),
    .wr_data (tx_if.tx_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign tx_if.tx_ready = !fifo_full;
  assign busy           = (state != ST_IDLE) || (fifo_count != '0);
  assign bit_done       = (cnt == CNT_LAST);
  assign pop            = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && bit_done));

  always_comb begin
    state_n = state;
    cnt_n   = bit_done ? '0 : cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (pop) begin
          state_n = ST_START;
          shift_n = fifo_rd_data;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_n = ST_DATA;
          idx_n   = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_n = shift >> 1;
          idx_n   = idx + 1'b1;
          if (idx == IDX_LAST) state_n = ST_STOP;
        end
      end
      default: begin
        if (bit_done) begin
          if (pop) begin
            state_n = ST_START;
            shift_n = fifo_rd_data;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
    endcase
  end

  // The line is driven from the next state so it changes on the same edge as the FSM.
  always_comb begin
    case (state_n)
      ST_START: line_n = START_BIT;
      ST_DATA:  line_n = shift_n[0];
      default:  line_n = STOP_BIT;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      uart_tx <= line_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed pushes feed an expected-byte queue; a line monitor
// decodes each 8N1 frame from uart_tx and compares it against that queue.
module tb_uart_tx_fifo;

  import uart_pkg::*;

  localparam int DF    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          sys_clk = 1'b0;
  logic          rst     = 1'b1;
  logic          uart_tx;
  logic          busy;
  logic [AW:0]   fifo_count;
  logic [1:0]    state;

  uart_tx_fifo_if tx_if ();

  uart_tx_fifo #(
    .DELAY_FRAMES (DF),
    .FIFO_DEPTH   (DEPTH),
    .ADDR_W       (AW)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .tx_if      (tx_if.slave),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .state      (state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // line monitor: one negedge-driven decoder, restarts on reset
  logic       mon_active = 1'b0;
  int         mon_pos    = 0;
  int         mon_frames = 0;
  logic [7:0] mon_byte   = '0;
  logic [2:0] mon_bit;

  always @(negedge sys_clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx == 1'b0) begin
        mon_active = 1'b1;
        mon_pos    = 0;
        mon_byte   = '0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_pos++;
      if (mon_pos == DF/2) begin
        check("start_bit", uart_tx, 1'b0);
      end else if (mon_pos > DF && mon_pos < 9*DF && (mon_pos % DF) == DF/2) begin
        mon_bit = 3'(mon_pos/DF - 1);
        mon_byte[mon_bit] = uart_tx;
      end else if (mon_pos == 9*DF + DF/2) begin
        check("stop_bit", uart_tx, 1'b1);
        mon_frames++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL frame_unexpected: got %02h expected no frame", mon_byte);
        end else begin
          check("frame_byte", mon_byte, exp_q.pop_front());
        end
      end else if (mon_pos == 10*DF - 1) begin
        mon_active = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic push_byte(input logic [7:0] b, output int acc_cyc);
    int n = 0;
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    while (!tx_if.tx_ready && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    if (!tx_if.tx_ready) begin
      check("push_timeout", 32'd0, 32'd1);
      acc_cyc = -1;
    end else begin
      @(posedge sys_clk);
      #1;
      acc_cyc = cyc;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge sys_clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || mon_active) && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 5000) check("idle_timeout", 32'd0, 32'd1);
  endtask

  int e0, e1, ea, frames_before;
  int acc[20];

  initial begin
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    repeat (2) @(negedge sys_clk);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_tx_ready", tx_if.tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_state", state, ST_IDLE);
    rst = 1'b0;
    @(negedge sys_clk);

    // single byte 0x41: line falls one edge after acceptance, 80-cycle frame
    start_q.delete();
    push_byte(8'h41, e0);
    tx_if.tx_valid = 1'b0;
    check("t1_count_after_push", fifo_count, 1);
    wait_cyc(e0 + 80);
    check("t1_busy_in_stop", busy, 1'b1);
    wait_cyc(e0 + 81);
    check("t1_busy_done", busy, 1'b0);
    check("t1_count_done", fifo_count, 0);
    check("t1_line_idle", uart_tx, 1'b1);
    check("t1_frames", start_q.size(), 1);
    if (start_q.size() > 0) check("t1_start_cycle", start_q[0], e0 + 1);

    // back-to-back 0x55, 0xAA: contiguous frames, 160 cycles total
    @(negedge sys_clk);
    start_q.delete();
    push_byte(8'h55, e0);
    push_byte(8'hAA, e1);
    tx_if.tx_valid = 1'b0;
    check("t2_consecutive_accept", e1 - e0, 1);
    wait_cyc(e0 + 160);
    check("t2_busy_in_stop", busy, 1'b1);
    wait_cyc(e0 + 161);
    check("t2_busy_done", busy, 1'b0);
    check("t2_frames", start_q.size(), 2);
    if (start_q.size() == 2) begin
      check("t2_first_start", start_q[0], e0 + 1);
      check("t2_frame_gap", start_q[1] - start_q[0], 10*DF);
    end

    // capacity and throttling with tx_valid held high
    @(negedge sys_clk);
    for (int i = 0; i < 20; i++) begin
      push_byte(8'(i), acc[i]);
      if (i == 16) begin
        check("t3_ready_low_when_full", tx_if.tx_ready, 1'b0);
        check("t3_count_full", fifo_count, 16);
        check("t3_accept_span", acc[16] - acc[0], 16);
      end
      if (i == 17) check("t3_first_refill", acc[17] - acc[0], 82);
      if (i >= 18) check("t3_refill_period", acc[i] - acc[i-1], 10*DF);
    end
    tx_if.tx_valid = 1'b0;
    wait_idle();
    check("t3_all_sent", exp_q.size(), 0);

    // asynchronous reset in the middle of a data bit with 3 bytes queued
    @(negedge sys_clk);
    push_byte(8'hF0, e0);
    push_byte(8'h01, ea);
    push_byte(8'h02, ea);
    push_byte(8'h03, ea);
    tx_if.tx_valid = 1'b0;
    check("t4_queued", fifo_count, 3);
    wait_cyc(e0 + 30);
    check("t4_state_data", state, ST_DATA);
    check("t4_line_low", uart_tx, 1'b0);
    frames_before = mon_frames;
    #2 rst = 1'b1;
    #1;
    check("t4_rst_line_high", uart_tx, 1'b1);
    check("t4_rst_count", fifo_count, 0);
    check("t4_rst_ready", tx_if.tx_ready, 1'b1);
    check("t4_rst_busy", busy, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    wait_cyc(cyc + 300);
    check("t4_no_frames", mon_frames - frames_before, 0);
    check("t4_line_idle", uart_tx, 1'b1);
    check("t4_idle_state", state, ST_IDLE);

    // serial decode of 0x2A
    frames_before = mon_frames;
    push_byte(8'h2A, e0);
    tx_if.tx_valid = 1'b0;
    wait_idle();
    check("t5_frames", mon_frames - frames_before, 1);
    check("t5_drained", exp_q.size(), 0);

    // push and pop on the same edge at the stop boundary with 5 queued
    @(negedge sys_clk);
    start_q.delete();
    frames_before = mon_frames;
    push_byte(8'h10, e0);
    for (int i = 1; i < 6; i++) push_byte(8'(8'h10 + i), ea);
    tx_if.tx_valid = 1'b0;
    wait_cyc(e0 + 80);
    check("t6_count_before", fifo_count, 5);
    check("t6_state_stop", state, ST_STOP);
    push_byte(8'h16, ea);
    tx_if.tx_valid = 1'b0;
    check("t6_accept_edge", ea, e0 + 81);
    check("t6_count_after", fifo_count, 5);
    check("t6_state_start", state, ST_START);
    wait_idle();
    check("t6_frames", mon_frames - frames_before, 7);
    if (start_q.size() >= 2) check("t6_no_gap", start_q[1] - start_q[0], 10*DF);
    check("t6_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
